// File: rtl/display_pkg.sv
// Shared types and default widths for the display-link register channel.
package display_pkg;

  localparam int unsigned NREQ_DEF     = 4;
  localparam int unsigned AW_DEF       = 16;
  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned TAGDEPTH_DEF = 4;
  localparam int unsigned TAGW         = $clog2(NREQ_DEF);

  typedef logic [TAGW-1:0] tag_t;

  typedef struct packed {
    logic              write;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/display_link_arbiter_if.sv
// Requester-side and link-side signal bundle of the display-link arbiter.
interface display_link_arbiter_if
  import display_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_data;
  logic               link_valid;
  logic               link_ready;
  logic               link_write;
  logic [AW-1:0]      link_addr;
  logic [DW-1:0]      link_wdata;
  logic               link_rvalid;
  logic [DW-1:0]      link_rdata;
  logic               err_orphan;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, link_ready, link_rvalid, link_rdata,
    input  req_ready, resp_valid, resp_data, link_valid, link_write, link_addr, link_wdata,
           err_orphan
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, link_ready, link_rvalid, link_rdata,
    output req_ready, resp_valid, resp_data, link_valid, link_write, link_addr, link_wdata,
           err_orphan
  );
endinterface

// File: rtl/display_tag_fifo.sv
// Ordered FIFO of requester tags for reads in flight on the link.
module display_tag_fifo
  import display_pkg::*;
#(
  parameter  int unsigned W     = TAGW,
  parameter  int unsigned DEPTH = TAGDEPTH_DEF,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  // A pop frees the slot a simultaneous push may need.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Tag storage, no reset needed: only read when occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/display_link_arbiter.sv
// Round-robin arbiter sharing the display-link register channel among requesters.
module display_link_arbiter
  import display_pkg::*;
#(
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned TAGDEPTH = TAGDEPTH_DEF
) (
  input  logic                    c125,
  input  logic                    reset,
  display_link_arbiter_if.slave   bus
);

  localparam int unsigned TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TAGDEPTH) + 1;

  logic [TW-1:0]   ptr_q;
  logic            link_valid_q;
  logic            link_write_q;
  logic [AW-1:0]   link_addr_q;
  logic [DW-1:0]   link_wdata_q;
  logic [NREQ-1:0] resp_valid_q;
  logic [DW-1:0]   resp_data_q;
  logic            err_orphan_q;

  logic            load_c;
  logic [NREQ-1:0] elig_c;
  logic            grant_any_c;
  logic [TW-1:0]   grant_idx_c;
  logic [NREQ-1:0] grant_oh_c;
  logic            push_c;

  logic [TW-1:0]   tag_head;
  logic [CW-1:0]   tag_count;
  logic            tag_empty;
  logic            tag_full;

  assign load_c = !link_valid_q || bus.link_ready;

  // Reads need a free tag slot (registered count); writes always eligible.
  always_comb begin
    elig_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig_c[i] = bus.req_valid[i] && (bus.req_write[i] || (tag_count < CW'(TAGDEPTH)));
    end
  end

  // First eligible requester scanning upward from the round-robin pointer.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!grant_any_c && elig_c[idx]) begin
        grant_any_c = 1'b1;
        grant_idx_c = TW'(idx);
      end
    end
  end

  assign grant_oh_c = (load_c && grant_any_c) ? (NREQ'(1) << grant_idx_c) : '0;
  assign push_c     = load_c && grant_any_c && !bus.req_write[grant_idx_c] && !tag_full;

  display_tag_fifo #(.W(TW), .DEPTH(TAGDEPTH)) u_tag_fifo (
    .clk   (c125),
    .rst_n (reset),
    .push  (push_c),
    .pop   (bus.link_rvalid),
    .din   (grant_idx_c),
    .dout  (tag_head),
    .count (tag_count),
    .empty (tag_empty),
    .full  (tag_full)
  );

  // Command output stage: load on grant, hold while the link back-pressures.
  always_ff @(posedge c125) begin
    if (!reset) begin
      ptr_q        <= '0;
      link_valid_q <= 1'b0;
      link_write_q <= 1'b0;
      link_addr_q  <= '0;
      link_wdata_q <= '0;
    end else if (load_c) begin
      if (grant_any_c) begin
        link_valid_q <= 1'b1;
        link_write_q <= bus.req_write[grant_idx_c];
        link_addr_q  <= bus.req_addr[32'(grant_idx_c)*AW +: AW];
        link_wdata_q <= bus.req_wdata[32'(grant_idx_c)*DW +: DW];
        ptr_q        <= TW'((32'(grant_idx_c) + 1) % NREQ);
      end else begin
        link_valid_q <= 1'b0;
      end
    end
  end

  // Route returned read data to the tag at the FIFO head; flag orphans.
  always_ff @(posedge c125) begin
    if (!reset) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      if (bus.link_rvalid) begin
        if (!tag_empty) begin
          resp_valid_q <= NREQ'(1) << tag_head;
          resp_data_q  <= bus.link_rdata;
        end else begin
          err_orphan_q <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready  = grant_oh_c;
  assign bus.link_valid = link_valid_q;
  assign bus.link_write = link_write_q;
  assign bus.link_addr  = link_addr_q;
  assign bus.link_wdata = link_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.err_orphan = err_orphan_q;

endmodule
